// File: rtl/coherency_config_issuer.sv
// coherency_config_issuer
// Accepts cache-line watch requests from the memory controller, rejects
// zero-size or misaligned ones with a one-cycle error pulse, queues the rest
// in arrival order and presents them one at a time to the coherency manager
// over a valid/ack handshake. The entry being presented stays in the FIFO
// until it is acknowledged, so DEPTH counts the in-flight entry too.
module coherency_config_issuer #(
   parameter int ADDR_WIDTH = 64,
   parameter int SIZE_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int LINE_LOG2  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_base_addr,
   input  logic [SIZE_WIDTH-1:0] req_size,
   output logic                  cfg_valid,
   output logic [ADDR_WIDTH-1:0] cfg_base_addr,
   output logic [SIZE_WIDTH-1:0] cfg_size,
   input  logic                  cfg_ack,
   output logic                  err_valid,
   output logic [1:0]            err_code,
   output logic                  busy,
   output logic [15:0]           issued_count
);

   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] base;
      logic [SIZE_WIDTH-1:0] size;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic [PTR_W:0]   rd_ptr_inc;
   logic [0:0]       state;

   logic             fifo_empty;
   logic             fifo_full;
   logic             accept;
   logic             size_zero;
   logic             misaligned;
   logic             enq;
   logic             pop;
   entry_t           req_entry;

   // Pointers carry one extra wrap bit: equal pointers mean empty, equal
   // index with differing wrap bit means full.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   // Ready depends only on pre-pop occupancy, never on req_valid or cfg_ack,
   // and is held low while the block sits in reset.
   assign req_ready  = rst_n && !fifo_full;

   assign accept     = req_valid && req_ready;
   assign size_zero  = (req_size == '0);
   assign misaligned = |req_base_addr[LINE_LOG2-1:0];
   assign enq        = accept && !size_zero && !misaligned;

   assign cfg_valid  = (state == ST_ISSUE);
   assign pop        = cfg_valid && cfg_ack;
   assign rd_ptr_inc = rd_ptr + PTR_ONE;
   assign busy       = !fifo_empty || cfg_valid;

   assign req_entry.base = req_base_addr;
   assign req_entry.size = req_size;

   // FIFO storage: written on every enqueue, read through the pointers.
   // NOTE: the payload array has no reset; the pointers alone decide which
   // entries are meaningful, so clearing the storage would only add logic.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[wr_ptr[PTR_W-1:0]] <= req_entry;
      end
   end

   // FIFO pointer bookkeeping; enqueue and pop may happen on the same edge.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr_inc;
         end
      end
   end

   // Issue FSM: loads the registered cfg payload from the FIFO head and, on
   // an ack, switches straight to the next entry (or the entry being written
   // this very cycle) so consecutive configurations leave no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         cfg_base_addr <= '0;
         cfg_size      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state         <= ST_ISSUE;
                  cfg_base_addr <= mem[rd_ptr[PTR_W-1:0]].base;
                  cfg_size      <= mem[rd_ptr[PTR_W-1:0]].size;
               end
            end
            ST_ISSUE: begin
               if (cfg_ack) begin
                  if (rd_ptr_inc != wr_ptr) begin
                     cfg_base_addr <= mem[rd_ptr_inc[PTR_W-1:0]].base;
                     cfg_size      <= mem[rd_ptr_inc[PTR_W-1:0]].size;
                  end else if (enq) begin
                     cfg_base_addr <= req_base_addr;
                     cfg_size      <= req_size;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Rejection reporting: one-cycle pulse after the offending acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_valid <= 1'b0;
         err_code  <= 2'b00;
      end else if (accept && (size_zero || misaligned)) begin
         err_valid <= 1'b1;
         err_code  <= {misaligned, size_zero};
      end else begin
         err_valid <= 1'b0;
         err_code  <= 2'b00;
      end
   end

   // Count of acknowledged configurations, wrapping naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_count <= '0;
      end else if (pop) begin
         issued_count <= issued_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_coherency_config_issuer.sv
// Directed bench for coherency_config_issuer: inputs change on the falling
// edge, outputs are compared on the falling edge after each rising edge.
module tb_coherency_config_issuer;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_base_addr;
   logic [31:0] req_size;
   logic        cfg_valid;
   logic [63:0] cfg_base_addr;
   logic [31:0] cfg_size;
   logic        cfg_ack;
   logic        err_valid;
   logic [1:0]  err_code;
   logic        busy;
   logic [15:0] issued_count;

   int passes = 0;
   int total  = 0;

   coherency_config_issuer #(
      .ADDR_WIDTH (64),
      .SIZE_WIDTH (32),
      .DEPTH      (4),
      .LINE_LOG2  (6)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_base_addr (req_base_addr),
      .req_size      (req_size),
      .cfg_valid     (cfg_valid),
      .cfg_base_addr (cfg_base_addr),
      .cfg_size      (cfg_size),
      .cfg_ack       (cfg_ack),
      .err_valid     (err_valid),
      .err_code      (err_code),
      .busy          (busy),
      .issued_count  (issued_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      total = total + 1;
      assert (observed === expected) passes = passes + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_req(input logic [63:0] base, input logic [31:0] size);
      req_valid     = 1'b1;
      req_base_addr = base;
      req_size      = size;
   endtask

   initial begin
      int sent;
      int guard;

      rst_n         = 1'b0;
      req_valid     = 1'b0;
      req_base_addr = '0;
      req_size      = '0;
      cfg_ack       = 1'b0;

      // Reset values
      tick();
      tick();
      check("rst_req_ready",  {63'd0, req_ready},  64'd0);
      check("rst_cfg_valid",  {63'd0, cfg_valid},  64'd0);
      check("rst_cfg_base",   cfg_base_addr,       64'd0);
      check("rst_cfg_size",   {32'd0, cfg_size},   64'd0);
      check("rst_err_valid",  {63'd0, err_valid},  64'd0);
      check("rst_err_code",   {62'd0, err_code},   64'd0);
      check("rst_busy",       {63'd0, busy},       64'd0);
      check("rst_issued",     {48'd0, issued_count}, 64'd0);

      rst_n = 1'b1;
      #1;
      check("ready_after_rst", {63'd0, req_ready}, 64'd1);
      @(negedge clk);

      // Single request, ack held high: cfg_valid two edges after acceptance
      cfg_ack = 1'b1;
      drive_req(64'h1000, 32'd4);
      check("t1_ready", {63'd0, req_ready}, 64'd1);
      tick();
      req_valid = 1'b0;
      check("t1_valid_e0", {63'd0, cfg_valid}, 64'd0);
      check("t1_busy_e0",  {63'd0, busy},      64'd1);
      tick();
      check("t1_valid_e1", {63'd0, cfg_valid},   64'd1);
      check("t1_base",     cfg_base_addr,        64'h1000);
      check("t1_size",     {32'd0, cfg_size},    64'd4);
      check("t1_cnt_pre",  {48'd0, issued_count}, 64'd0);
      tick();
      check("t1_valid_e2", {63'd0, cfg_valid},   64'd0);
      check("t1_cnt",      {48'd0, issued_count}, 64'd1);
      check("t1_busy_end", {63'd0, busy},        64'd0);

      // Rejected requests
      cfg_ack = 1'b0;
      drive_req(64'h2000, 32'd0);
      tick();
      check("t2_zero_err",  {63'd0, err_valid}, 64'd1);
      check("t2_zero_code", {62'd0, err_code},  64'd1);
      check("t2_zero_busy", {63'd0, busy},      64'd0);
      drive_req(64'h1004, 32'd2);
      tick();
      check("t2_mis_err",  {63'd0, err_valid}, 64'd1);
      check("t2_mis_code", {62'd0, err_code},  64'd2);
      drive_req(64'h1005, 32'd0);
      tick();
      check("t2_both_code", {62'd0, err_code}, 64'd3);
      req_valid = 1'b0;
      tick();
      check("t2_err_clear", {63'd0, err_valid}, 64'd0);
      check("t2_code_clear", {62'd0, err_code}, 64'd0);
      tick();
      check("t2_no_cfg",  {63'd0, cfg_valid}, 64'd0);
      check("t2_no_busy", {63'd0, busy},      64'd0);

      // Five back-to-back requests with no ack: four fit, fifth refused
      for (int i = 0; i < 5; i++) begin
         drive_req(64'(i + 1) << 8, 32'(i + 1));
         check($sformatf("t3_ready_%0d", i), {63'd0, req_ready},
               (i < 4) ? 64'd1 : 64'd0);
         tick();
      end
      // Full FIFO with a pop this cycle: ready still low
      cfg_ack = 1'b1;
      check("t3_full_pop_ready", {63'd0, req_ready}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_valid_%0d", i), {63'd0, cfg_valid},  64'd1);
         check($sformatf("t3_base_%0d", i),  cfg_base_addr,       64'(i + 1) << 8);
         check($sformatf("t3_size_%0d", i),  {32'd0, cfg_size},   64'(i + 1));
         tick();
         req_valid = 1'b0;
      end
      check("t3_idle",  {63'd0, cfg_valid},    64'd0);
      check("t3_cnt",   {48'd0, issued_count}, 64'd5);
      check("t3_busy",  {63'd0, busy},         64'd0);

      // Ack delayed 7 cycles: payload stable, pop only on the ack
      cfg_ack = 1'b0;
      drive_req(64'h4000, 32'd9);
      tick();
      req_valid = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) begin
         check($sformatf("t4_valid_%0d", i), {63'd0, cfg_valid},    64'd1);
         check($sformatf("t4_base_%0d", i),  cfg_base_addr,         64'h4000);
         check($sformatf("t4_size_%0d", i),  {32'd0, cfg_size},     64'd9);
         check($sformatf("t4_cnt_%0d", i),   {48'd0, issued_count}, 64'd5);
         tick();
      end
      cfg_ack = 1'b1;
      check("t4_valid_ack", {63'd0, cfg_valid}, 64'd1);
      tick();
      check("t4_done", {63'd0, cfg_valid},    64'd0);
      check("t4_cnt",  {48'd0, issued_count}, 64'd6);

      // Ack while idle is ignored
      tick();
      check("t5_idle_ack_cnt", {48'd0, issued_count}, 64'd6);

      // Enqueue on the same edge as the ack of the last entry
      cfg_ack = 1'b0;
      drive_req(64'h5000, 32'd1);
      tick();
      req_valid = 1'b0;
      tick();
      check("t6_first", cfg_base_addr, 64'h5000);
      drive_req(64'h6000, 32'd2);
      cfg_ack = 1'b1;
      tick();
      req_valid = 1'b0;
      cfg_ack   = 1'b0;
      check("t6_valid", {63'd0, cfg_valid},    64'd1);
      check("t6_base",  cfg_base_addr,         64'h6000);
      check("t6_size",  {32'd0, cfg_size},     64'd2);
      check("t6_cnt",   {48'd0, issued_count}, 64'd7);
      cfg_ack = 1'b1;
      tick();
      check("t6_done", {63'd0, cfg_valid},    64'd0);
      check("t6_cnt2", {48'd0, issued_count}, 64'd8);

      // Reset while issuing with three entries queued
      cfg_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_req(64'h7000 + (64'(i) << 6), 32'd3);
         tick();
      end
      req_valid = 1'b0;
      check("t7_pre_valid", {63'd0, cfg_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("t7_valid",  {63'd0, cfg_valid},    64'd0);
      check("t7_base",   cfg_base_addr,         64'd0);
      check("t7_size",   {32'd0, cfg_size},     64'd0);
      check("t7_busy",   {63'd0, busy},         64'd0);
      check("t7_cnt",    {48'd0, issued_count}, 64'd0);
      check("t7_ready",  {63'd0, req_ready},    64'd0);
      check("t7_err",    {63'd0, err_valid},    64'd0);
      @(negedge clk);
      tick();
      rst_n   = 1'b1;
      cfg_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t7_post_valid_%0d", i), {63'd0, cfg_valid}, 64'd0);
      end
      check("t7_post_busy", {63'd0, busy},         64'd0);
      check("t7_post_cnt",  {48'd0, issued_count}, 64'd0);

      // Counter wrap: 65535 handshakes, then one more
      sent = 0;
      guard = 0;
      while (sent < 65535 && guard < 80000) begin
         drive_req(64'h8000, 32'd1);
         if (req_ready) sent = sent + 1;
         tick();
         guard = guard + 1;
      end
      req_valid = 1'b0;
      guard = 0;
      while (busy && guard < 20) begin
         tick();
         guard = guard + 1;
      end
      check("t8_drained", {63'd0, busy},         64'd0);
      check("t8_ffff",    {48'd0, issued_count}, 64'hFFFF);
      drive_req(64'h9000, 32'd5);
      tick();
      req_valid = 1'b0;
      tick();
      check("t8_last_base", cfg_base_addr, 64'h9000);
      tick();
      check("t8_wrap", {48'd0, issued_count}, 64'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/coherency_config_issuer.md
COHERENCY_CONFIG_ISSUER -- requirements
Module: coherency_config_issuer

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, width of base address (matches addr_t).
REQ-002 Parameter SIZE_WIDTH, default 32, width of line count (matches size_t).
REQ-003 Parameter DEPTH, default 4, request FIFO entries; power of two, at least 2.
REQ-004 Parameter LINE_LOG2, default 6, log2 of cache-line bytes.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  memory controller offers a watch request.
REQ-008 req_ready  output  1  block accepts request this cycle.
REQ-009 req_base_addr  input  ADDR_WIDTH  byte base address to watch.
REQ-010 req_size  input  SIZE_WIDTH  number of cache lines to watch.
REQ-011 cfg_valid  output  1  master-side valid toward the coherency manager.
REQ-012 cfg_base_addr  output  ADDR_WIDTH  master-side base address.
REQ-013 cfg_size  output  SIZE_WIDTH  master-side line count.
REQ-014 cfg_ack  input  1  coherency manager accepted the configuration.
REQ-015 err_valid  output  1  one-cycle pulse: request rejected.
REQ-016 err_code  output  2  01 size zero, 10 misaligned base, 11 both; valid only with err_valid.
REQ-017 busy  output  1  FIFO non-empty or cfg_valid high.
REQ-018 issued_count  output  16  configurations acknowledged since reset.

Function
REQ-019 Request accepted on a cycle with req_valid && req_ready; req_ready = FIFO not full, independent of req_valid.
REQ-020 Accepted request checked: req_size == 0 or req_base_addr[LINE_LOG2-1:0] != 0 rejects it; a rejected request is not enqueued.
REQ-021 err_valid pulses the cycle after the rejected acceptance, with the matching err_code.
REQ-022 Valid requests are enqueued in arrival order; FIFO of DEPTH entries.
REQ-023 FSM states IDLE and ISSUE; IDLE -> ISSUE when FIFO non-empty; ISSUE -> IDLE on cfg_valid && cfg_ack with FIFO empty after the pop; ISSUE stays on cfg_ack with more entries.
REQ-024 cfg_valid high exactly in ISSUE; cfg_base_addr/cfg_size are the FIFO head, registered.
REQ-025 While cfg_valid is high without cfg_ack, cfg_valid, cfg_base_addr, and cfg_size hold stable.
REQ-026 Handshake completes on cycle with cfg_valid && cfg_ack; head pops same edge; next entry drives cfg outputs the following cycle (back-to-back, no bubble).
REQ-027 Latency: valid request into empty, idle block -> cfg_valid high on the second rising edge after acceptance.
REQ-028 cfg_ack while cfg_valid low is ignored.
REQ-029 Simultaneous enqueue and pop when full: req_ready stays low that cycle (ready from pre-pop state), no entry lost.
REQ-030 Simultaneous enqueue into an empty FIFO and an ack on the last entry: new entry issues next cycle, FSM stays ISSUE.
REQ-031 issued_count increments by 1 per completed handshake and wraps 0xFFFF -> 0x0000.
REQ-032 FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty come from the pointer MSB comparison.

Reset
REQ-033 While rst_n is low: FSM IDLE, FIFO empty, cfg_valid 0, cfg_base_addr 0, cfg_size 0, err_valid 0, err_code 0, busy 0, issued_count 0, req_ready 0.
REQ-034 req_ready is 1 on the first cycle after rst_n deasserts.
REQ-035 Reset mid-handshake drops all queued and in-flight requests; no cfg_valid after release until a new request.

Verification
REQ-036 Single request base=0x1000, size=4, ack held 1 -> cfg_valid rises 2 cycles after acceptance, payload 0x1000/4, issued_count=1, busy falls.
REQ-037 Request size=0 -> err_valid pulse, err_code=01; base=0x1004 size=2 -> err_code=10; neither reaches cfg_valid.
REQ-038 Five valid requests back-to-back with cfg_ack=0 -> four accepted, req_ready=0 on the fifth; ack held 1 -> four consecutive handshakes in order, no bubbles.
REQ-039 cfg_ack delayed 7 cycles -> cfg_valid and payload stable all 7 cycles; pop only on the ack cycle.
REQ-040 rst_n asserted while cfg_valid=1 with 3 entries queued -> all outputs at reset values; after release, idle until a new request.
REQ-041 Preload issued_count to 0xFFFF via 65535 handshakes, one more -> 0x0000.
